// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store type encodings and LSU state enum
//
// Contents: dm_select load codes, store_select store codes, LSU FSM states.

package riscv_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b011;
  localparam logic [2:0] DM_LHU = 3'b100;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_RD   = 2'b01,
    LSU_WR   = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - lane select, load extension, store merge, alignment check
//
// Ports:
//   is_store     in  1   selects which type field drives the alignment check
//   dm_select    in  3   load type
//   store_select in  2   store type
//   addr_lo      in  2   byte offset within the word
//   mem_word     in  32  word read from memory
//   store_data   in  32  rs2 store data
//   load_val     out 32  aligned and extended load result
//   merge_word   out 32  word to write back (read word with the store lanes replaced)
//   misaligned   out 1   access crosses its natural alignment

module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  dm_select,
  input  logic [1:0]  store_select,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merge_word,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    load_val = mem_word;
    case (dm_select)
      DM_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      DM_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      DM_LBU:  load_val = {24'h000000, byte_sel};
      DM_LHU:  load_val = {16'h0000, half_sel};
      default: load_val = mem_word;
    endcase

    merge_word = mem_word;
    case (store_select)
      ST_SB: merge_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      ST_SH: begin
        if (addr_lo[1]) merge_word[31:16] = store_data[15:0];
        else            merge_word[15:0]  = store_data[15:0];
      end
      default: merge_word = store_data;
    endcase

    misaligned = 1'b0;
    if (is_store) begin
      case (store_select)
        ST_SW:   misaligned = |addr_lo;
        ST_SH:   misaligned = addr_lo[0];
        default: misaligned = 1'b0;
      endcase
    end else begin
      case (dm_select)
        DM_LW:         misaligned = |addr_lo;
        DM_LH, DM_LHU: misaligned = addr_lo[0];
        default:       misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - multi-cycle load/store unit with req/ack word memory port
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid, mem_read,         access request from the decoder; operands
//   mem_write, dm_select,        are held stable by the core while stall=1
//   store_select, addr, wdata
//   stall                        freeze PC / register file (combinational)
//   done, fault, rdata           completion pulse, error flag, load result
//   m_req, m_we, m_addr,         word-wide memory request (registered)
//   m_wdata
//   m_ack, m_rdata               memory acknowledge and read data

module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  dm_select,
  input  logic [1:0]  store_select,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  lsu_state_e  state;
  logic        op_store;
  logic [2:0]  op_dm;
  logic [1:0]  op_st;
  logic [1:0]  op_lo;
  logic [31:0] op_wdata;
  logic [31:0] wait_cnt;

  // The aligner sees the live inputs while deciding in IDLE and the latched
  // operands once the access is under way.
  logic        sel_store;
  logic [2:0]  sel_dm;
  logic [1:0]  sel_st;
  logic [1:0]  sel_lo;
  logic [31:0] sel_wdata;
  logic [31:0] load_val;
  logic [31:0] merge_word;
  logic        misaligned;

  logic        bad_type;
  logic        req_fault;
  logic        ack;
  logic        timed_out;

  assign sel_store = (state == LSU_IDLE) ? mem_write    : op_store;
  assign sel_dm    = (state == LSU_IDLE) ? dm_select    : op_dm;
  assign sel_st    = (state == LSU_IDLE) ? store_select : op_st;
  assign sel_lo    = (state == LSU_IDLE) ? addr[1:0]    : op_lo;
  assign sel_wdata = (state == LSU_IDLE) ? wdata        : op_wdata;

  riscv_lsu_align u_align (
    .is_store     (sel_store),
    .dm_select    (sel_dm),
    .store_select (sel_st),
    .addr_lo      (sel_lo),
    .mem_word     (m_rdata),
    .store_data   (sel_wdata),
    .load_val     (load_val),
    .merge_word   (merge_word),
    .misaligned   (misaligned)
  );

  // Only the type field belonging to the requested direction is checked.
  assign bad_type  = mem_read ? (dm_select > DM_LHU) : (store_select == 2'b11);
  assign req_fault = (mem_read == mem_write) | bad_type | misaligned;
  assign ack       = m_req & m_ack;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);

  assign stall = !rst && ((state == LSU_IDLE && req_valid) ||
                          state == LSU_RD || state == LSU_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LSU_IDLE;
      op_store <= 1'b0;
      op_dm    <= 3'b000;
      op_st    <= 2'b00;
      op_lo    <= 2'b00;
      op_wdata <= 32'h0;
      wait_cnt <= 32'h0;
      done     <= 1'b0;
      fault    <= 1'b0;
      rdata    <= 32'h0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            op_store <= mem_write;
            op_dm    <= dm_select;
            op_st    <= store_select;
            op_lo    <= addr[1:0];
            op_wdata <= wdata;
            wait_cnt <= 32'h0;
            if (req_fault) begin
              state <= LSU_DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              if (mem_read) rdata <= 32'h0;
            end else begin
              m_req  <= 1'b1;
              m_addr <= {addr[31:2], 2'b00};
              if (mem_write && store_select == ST_SW) begin
                state   <= LSU_WR;
                m_we    <= 1'b1;
                m_wdata <= wdata;
              end else begin
                // Loads and sub-word stores both start with a read.
                state <= LSU_RD;
                m_we  <= 1'b0;
              end
            end
          end
        end

        LSU_RD: begin
          if (ack) begin
            if (op_store) begin
              state    <= LSU_WR;
              m_we     <= 1'b1;
              m_wdata  <= merge_word;
              wait_cnt <= 32'h0;
            end else begin
              state <= LSU_DONE;
              m_req <= 1'b0;
              done  <= 1'b1;
              fault <= 1'b0;
              rdata <= load_val;
            end
          end else if (timed_out) begin
            state <= LSU_DONE;
            m_req <= 1'b0;
            done  <= 1'b1;
            fault <= 1'b1;
            if (!op_store) rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        LSU_WR: begin
          if (ack || timed_out) begin
            state <= LSU_DONE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            done  <= 1'b1;
            fault <= !ack;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        default: begin
          state <= LSU_IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed and randomized self-checking bench for riscv_lsu

module tb_riscv_lsu;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  dm_select = 3'b000;
  logic [1:0]  store_select = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:63];
  int          n_writes = 0;
  int          mem_wait = 0;
  bit          ack_en = 1'b1;
  int          wcnt = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dm_select    (dm_select),
    .store_select (store_select),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .fault        (fault),
    .rdata        (rdata),
    .m_req        (m_req),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_ack        (m_ack),
    .m_rdata      (m_rdata)
  );

  always #5 clk = ~clk;

  // Memory: each request phase waits mem_wait cycles, then acks for one cycle.
  always @(negedge clk) begin
    if (m_ack) begin
      m_ack = 1'b0;
      wcnt  = 0;
    end
    if (m_req && !rst) begin
      if (ack_en && wcnt >= mem_wait) begin
        m_ack   = 1'b1;
        m_rdata = mem[m_addr[7:2]];
        if (m_we) begin
          mem[m_addr[7:2]] = m_wdata;
          n_writes++;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-level view of the access computed from sizes and offsets.
  task automatic ref_model(input bit rd, input logic [2:0] dm, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                           output bit flt, output logic [31:0] res,
                           output logic [31:0] nword, output int phases);
    int size;
    bit sgn;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    sh = 8 * int'(a[1:0]);
    sgn = 1'b0;
    size = 0;
    if (rd) begin
      case (dm)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd3: size = 1;
        3'd4: size = 2;
        default: size = 0;
      endcase
    end else begin
      case (st)
        2'd0: size = 4;
        2'd1: size = 2;
        2'd2: size = 1;
        default: size = 0;
      endcase
    end
    flt = (size == 0) || ((int'(a[1:0]) % size) != 0);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    res = 32'h0;
    nword = word;
    phases = 0;
    if (!flt) begin
      if (rd) begin
        v = (word >> sh) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        res = v;
        phases = 1;
      end else begin
        nword = (word & ~(mask << sh)) | ((wd & mask) << sh);
        phases = (size == 4) ? 1 : 2;
      end
    end
  endtask

  task automatic run(input bit rd, input bit wr, input logic [2:0] dm, input logic [1:0] st,
                     input logic [31:0] a, input logic [31:0] wd, input int waits, input bit ack_on,
                     output int lat, output bit got_done, output bit flt_o, output logic [31:0] rd_o,
                     output bit saw_req, output bit addr_ok, output bit stall_ok, output bit req_at_done);
    @(negedge clk);
    mem_read = rd; mem_write = wr; dm_select = dm; store_select = st;
    addr = a; wdata = wd; mem_wait = waits; ack_en = ack_on;
    req_valid = 1'b1;
    lat = 0; got_done = 1'b0; saw_req = 1'b0; addr_ok = 1'b1; req_at_done = 1'b0;
    flt_o = 1'b0; rd_o = 32'h0;
    #1;
    stall_ok = (stall === 1'b1);
    while (lat < 40 && !got_done) begin
      @(negedge clk);
      lat++;
      if (m_req === 1'b1) begin
        saw_req = 1'b1;
        if (m_addr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        flt_o = fault;
        rd_o = rdata;
        req_at_done = m_req;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int lat;
    bit gd, fl, sr, aok, sok, rq;
    logic [31:0] rv;
    logic [31:0] exp_rd;
    int wr0;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_m_req", {31'h0, m_req}, 32'h0);
    check("rst_m_we", {31'h0, m_we}, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Illegal direction combinations fault immediately without bus activity
    run(1'b1, 1'b1, 3'd2, 2'd0, 32'h100, 32'h0, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("both_lat", 32'(lat), 32'd1);
    check("both_fault", {31'h0, fl}, 32'h1);
    check("both_noreq", {31'h0, sr}, 32'h0);
    run(1'b0, 1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("none_lat", 32'(lat), 32'd1);
    check("none_fault", {31'h0, fl}, 32'h1);
    check("none_noreq", {31'h0, sr}, 32'h0);

    // LB sign-extended from byte 3
    mem[6'h00] = 32'h80FF_1234;
    run(1'b1, 1'b0, 3'd0, 2'd0, 32'h103, 32'h0, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_rdata", rv, 32'hFFFF_FF80);
    check("lb_fault", {31'h0, fl}, 32'h0);
    check("lb_maddr", {31'h0, aok}, 32'h1);
    check("lb_stall", {31'h0, sok}, 32'h1);

    // LHU upper half, 3 wait cycles
    mem[6'h00] = 32'h8001_7F00;
    run(1'b1, 1'b0, 3'd4, 2'd0, 32'h102, 32'h0, 3, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("lhu_lat", 32'(lat), 32'd5);
    check("lhu_rdata", rv, 32'h0000_8001);
    check("lhu_stall", {31'h0, sok}, 32'h1);

    // SB read-modify-write
    mem[6'h00] = 32'h1122_3344;
    wr0 = n_writes;
    run(1'b0, 1'b1, 3'd0, 2'd2, 32'h201, 32'h0000_00AB, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_mem", mem[6'h00], 32'h1122_AB44);
    check("sb_writes", 32'(n_writes - wr0), 32'd1);
    check("sb_rdata_kept", rv, 32'h0000_8001);
    check("sb_fault", {31'h0, fl}, 32'h0);

    // Misaligned LW and reserved store type
    run(1'b1, 1'b0, 3'd2, 2'd0, 32'h102, 32'h0, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("lwmis_lat", 32'(lat), 32'd1);
    check("lwmis_fault", {31'h0, fl}, 32'h1);
    check("lwmis_noreq", {31'h0, sr}, 32'h0);
    check("lwmis_rdata", rv, 32'h0);
    run(1'b0, 1'b1, 3'd0, 2'd3, 32'h100, 32'h5555, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("st11_lat", 32'(lat), 32'd1);
    check("st11_fault", {31'h0, fl}, 32'h1);
    check("st11_noreq", {31'h0, sr}, 32'h0);
    exp_rd = 32'h0;

    // Timeout on SH with no acknowledge
    wr0 = n_writes;
    mem[6'h01] = 32'hCAFE_F00D;
    run(1'b0, 1'b1, 3'd0, 2'd1, 32'h106, 32'h1234, 0, 1'b0, lat, gd, fl, rv, sr, aok, sok, rq);
    check("tmo_done", {31'h0, gd}, 32'h1);
    check("tmo_fault", {31'h0, fl}, 32'h1);
    check("tmo_mreq_drop", {31'h0, rq}, 32'h0);
    check("tmo_nowrite", 32'(n_writes - wr0), 32'd0);
    check("tmo_mem", mem[6'h01], 32'hCAFE_F00D);
    check("tmo_rdata", rv, exp_rd);

    // Reset pulsed while in WR
    wr0 = n_writes;
    @(negedge clk);
    mem_write = 1'b1; store_select = 2'd0; addr = 32'h108; wdata = 32'hDEAD_BEEF;
    ack_en = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    check("rstwr_in_wr", {30'h0, m_req, m_we}, 32'h3);
    rst = 1'b1;
    #1;
    check("rstwr_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_write = 1'b0;
    check("rstwr_mreq", {31'h0, m_req}, 32'h0);
    check("rstwr_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    check("rstwr_done2", {31'h0, done}, 32'h0);
    check("rstwr_nowrite", 32'(n_writes - wr0), 32'd0);
    ack_en = 1'b1;
    mem[6'h02] = 32'h0BAD_F00D;
    run(1'b1, 1'b0, 3'd2, 2'd0, 32'h108, 32'h0, 0, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
    check("postrst_lat", 32'(lat), 32'd2);
    check("postrst_rdata", rv, 32'h0BAD_F00D);
    exp_rd = 32'h0BAD_F00D;

    // Randomized accesses against the reference model
    for (int n = 0; n < 60; n++) begin
      bit r_rd;
      logic [2:0] r_dm;
      logic [1:0] r_st;
      logic [31:0] r_a, r_wd, r_word, e_res, e_word;
      int r_w, e_ph, e_lat;
      bit e_flt;
      r_rd   = 1'($urandom_range(0, 1));
      r_dm   = 3'($urandom_range(0, 7));
      r_st   = 2'($urandom_range(0, 3));
      r_a    = 32'h0000_1000 | 32'($urandom_range(0, 255));
      r_wd   = $urandom;
      r_word = $urandom;
      r_w    = $urandom_range(0, 3);
      mem[r_a[7:2]] = r_word;
      ref_model(r_rd, r_dm, r_st, r_a, r_wd, r_word, e_flt, e_res, e_word, e_ph);
      e_lat = e_flt ? 1 : 1 + e_ph * (1 + r_w);
      if (r_rd) exp_rd = e_res;
      wr0 = n_writes;
      run(r_rd, !r_rd, r_dm, r_st, r_a, r_wd, r_w, 1'b1, lat, gd, fl, rv, sr, aok, sok, rq);
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(e_lat));
      check($sformatf("rnd%0d_fault", n), {31'h0, fl}, {31'h0, e_flt});
      check($sformatf("rnd%0d_rdata", n), rv, exp_rd);
      check($sformatf("rnd%0d_mem", n), mem[r_a[7:2]], e_word);
      check($sformatf("rnd%0d_writes", n), 32'(n_writes - wr0), 32'((!r_rd && !e_flt) ? 1 : 0));
      check($sformatf("rnd%0d_req", n), {31'h0, sr}, {31'h0, !e_flt});
      check($sformatf("rnd%0d_maddr", n), {31'h0, aok}, 32'h1);
      check($sformatf("rnd%0d_stall", n), {31'h0, sok}, 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Multi-cycle load/store unit for the single-cycle RISC-V core. It consumes the memory controls issued by the control decoder (`mem_read`, `mem_write`, `dm_select`, `store_select`) together with the ALU address and rs2 data, and executes the access on a word-wide req/ack data-memory port. Sub-word stores are done as read-modify-write. The unit stalls the core until the access completes, then returns the aligned, sign- or zero-extended load data for the register-file write-back path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles waited for `m_ack` before a fault is raised; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: current instruction is a memory access; operands are held stable while `stall` is high.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `dm_select` in 3: load type. 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- `store_select` in 2: store type. 00 SW, 01 SH, 10 SB.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `stall` out 1: freeze PC and register file.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; the access was rejected or aborted.
- `rdata` out 32: load result, valid when `done` is high.
- `m_req` out 1: memory request.
- `m_we` out 1: memory write enable.
- `m_addr` out 32: word address `{addr[31:2],2'b00}`.
- `m_wdata` out 32: memory write data.
- `m_ack` in 1: memory acknowledge.
- `m_rdata` in 32: memory read data, valid when `m_ack` is high.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **IDLE, on `req_valid`:** latch the operands and select the next state.
  - Fault conditions go to DONE with `fault`=1 and no bus activity:
    - `mem_read` and `mem_write` both high.
    - Neither `mem_read` nor `mem_write` is high.
    - `dm_select` is 101–111, or `store_select` is 11.
    - Misaligned access: LH/LHU/SH need `addr[0]`=0; LW/SW need `addr[1:0]`=0.
  - Load, SB, or SH goes to RD.
  - SW goes to WR with `m_wdata`=`wdata`.
- **RD:** `m_req`=1, `m_we`=0.
  - On `m_ack`, capture `m_rdata`.
  - For a load, go to DONE.
  - For SB/SH, go to WR with merged data.
- **WR:** `m_req`=1, `m_we`=1. On `m_ack`, go to DONE.
- **DONE:** `done`=1, then return to IDLE. `req_valid` is ignored in DONE.
- **Timeout:** the wait counter clears on entry to RD or WR. When it reaches `TIMEOUT_CYCLES`, go to DONE with `fault`=1 and drop `m_req`. An aborted RMW performs no write.
- **Lanes:** little-endian; byte k is `m_rdata[8k+7:8k]`.
  - Byte lane is selected by `addr[1:0]`.
  - Half lane is selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Merge:**
  - SB replaces byte `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half `addr[1]` with `wdata[15:0]`.
  - All other bits keep the captured read word.
- **`rdata` update:**
  - Updated only at entry to DONE for loads.
  - Set to 0 on a faulted load.
  - Unchanged on stores.

## Timing
- **Registered outputs:** `m_req`, `m_we`, `m_addr`, `m_wdata`, `done`, `fault`, `rdata`.
- **`stall`** is combinational: (IDLE & `req_valid`) | RD | WR. It is 0 while `rst` is high and 0 in DONE, so the core commits at the DONE edge.
- **Handshake:**
  - `m_ack` is honoured only while `m_req` is high.
  - `m_addr`, `m_we` and `m_wdata` are held stable from `m_req` rise to the ack.
  - `m_req` deasserts the cycle after the ack.
  - Back-to-back RD→WR deasserts `m_req` for zero cycles; `m_we` switches at the transition.
- **Latency** (cycle 0 = `req_valid` seen in IDLE; memory with zero-wait ack):
  - Load / SW: `done` at cycle 2.
  - SB/SH: `done` at cycle 3.
  - Fault in IDLE: `done` at cycle 1.
  - Each memory wait cycle adds 1.
- **Reset values:** all registered outputs 0; state IDLE.
- **Reset mid-access:** return to IDLE at the edge; `m_req` is 0 the following cycle; no `done` is produced.

## Structure
- Shared package `riscv_pkg` holds:
  - `DM_LB`/`DM_LH`/`DM_LW`/`DM_LBU`/`DM_LHU` constants.
  - `ST_SW`/`ST_SH`/`ST_SB` constants.
  - The LSU state enum.
- One combinational sub-module `riscv_lsu_align`:
  - Inputs: type, `addr[1:0]`, memory word, store data.
  - Outputs: extended load value, merged write word, misaligned flag.
- The FSM, timeout counter and handshake registers stay in `riscv_lsu`.

## Test plan
- **LB:** `addr`=0x103, mem word 0x80FF_1234 (zero-wait) → `m_addr`=0x100, `rdata`=0xFFFF_FF80, `done` at cycle 2, `fault`=0.
- **LHU:** `addr`=0x102, mem word 0x8001_7F00, `m_ack` delayed 3 cycles → `rdata`=0x0000_8001, `done` at cycle 5, `stall` high cycles 0–4.
- **SB:** `addr`=0x201, `wdata`=0xAB, mem word 0x1122_3344 → read then write 0x1122_AB44 to 0x200, `done` at cycle 3.
- **Faults without bus activity:** LW at `addr`=0x102, and `store_select`=11 → `fault`=1, `done` at cycle 1, `m_req` never high.
- **Timeout:** `TIMEOUT_CYCLES`=4, SH with `m_ack` tied low → `fault`=1, `m_req` dropped, no write issued.
- **Reset mid-access:** `rst` pulsed in WR → `m_req`=0 the next cycle, no `done`, state IDLE; a following LW completes normally.
